// File: rtl/sim_psd_ddr_burst_model.sv
// Pseudo DDR local-interface model: bursts, byte enables, fixed read latency,
// init delay and periodic refresh stalls. Intended for fast simulation only.
module sim_psd_ddr_burst_model #(
  parameter int unsigned DDR_ADDR_WIDTH = 26,
  parameter int unsigned DDR_DATA_WIDTH = 128,
  parameter int unsigned MEM_DEPTH_LOG2 = 16,
  parameter int unsigned MAX_BURST      = 4,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned INIT_CYCLES    = 16,
  parameter int unsigned REFRESH_PERIOD = 0,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic                          phy_clk,
  input  logic                          phy_rst,
  output logic                          local_init_done,
  input  logic [DDR_ADDR_WIDTH-1:0]     local_address,
  input  logic                          local_burstbegin,
  input  logic [$clog2(MAX_BURST):0]    local_size,
  output logic                          local_ready,
  input  logic                          local_read_req,
  input  logic                          local_write_req,
  input  logic [DDR_DATA_WIDTH-1:0]     local_wdata,
  input  logic [DDR_DATA_WIDTH/8-1:0]   local_be,
  output logic [DDR_DATA_WIDTH-1:0]     local_rdata,
  output logic                          local_rdata_valid,
  output logic                          proto_err
);
  localparam int unsigned SZW        = $clog2(MAX_BURST) + 1;
  localparam int unsigned NBE        = DDR_DATA_WIDTH / 8;
  localparam int unsigned DEPTH      = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned PIPE       = RD_LATENCY - 1;
  localparam int unsigned INIT_LAST  = (INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0;
  localparam int unsigned REF_LAST   = (REFRESH_PERIOD > 0) ? REFRESH_PERIOD - 1 : 0;
  localparam int unsigned STALL_LAST = (REFRESH_CYCLES > 1) ? REFRESH_CYCLES - 2 : 0;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR_BURST, S_RD_GEN, S_REFRESH} state_e;

  state_e                    state_q, state_d;
  logic [31:0]               init_cnt_q, init_cnt_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SZW-1:0]            size_q, size_d;
  logic [SZW-1:0]            beat_q, beat_d;
  logic [31:0]               ref_cnt_q, ref_cnt_d;
  logic                      ref_pend_q, ref_pend_d;
  logic [31:0]               stall_q, stall_d;
  logic                      proto_q, proto_d;

  logic [DDR_DATA_WIDTH-1:0] mem [DEPTH];
  logic [PIPE-1:0]           pv_q;
  logic [DDR_DATA_WIDTH-1:0] pd_q [PIPE];
  logic                      rvalid_q;
  logic [DDR_DATA_WIDTH-1:0] rdata_q;

  logic [SZW-1:0]            size_eff;
  logic [DDR_ADDR_WIDTH-1:0] cur_line, wr_line;
  logic [DDR_DATA_WIDTH-1:0] mem_rd;
  logic                      wr_en, inject, ref_clr, ref_tick, req, wr_acc, rd_acc;
  logic                      unused_hi;

  always_comb begin
    if (local_size == '0)                     size_eff = SZW'(1);
    else if (local_size > SZW'(MAX_BURST))    size_eff = SZW'(MAX_BURST);
    else                                      size_eff = local_size;
  end

  assign local_init_done   = (state_q != S_INIT);
  assign local_ready       = (state_q == S_WR_BURST) || (state_q == S_IDLE && !ref_pend_q);
  assign local_rdata       = rdata_q;
  assign local_rdata_valid = rvalid_q;
  assign proto_err         = proto_q;

  assign req      = local_read_req || local_write_req;
  assign wr_acc   = local_write_req && local_burstbegin && local_ready;
  assign rd_acc   = local_read_req && local_burstbegin && local_ready && !local_write_req;
  assign cur_line = addr_q + DDR_ADDR_WIDTH'(beat_q);
  assign mem_rd   = mem[cur_line[MEM_DEPTH_LOG2-1:0]];
  assign ref_tick = (REFRESH_PERIOD != 0) && (state_q != S_INIT) && (ref_cnt_q == REF_LAST);
  assign unused_hi = ^wr_line[DDR_ADDR_WIDTH-1:MEM_DEPTH_LOG2];

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    wr_en      = 1'b0;
    wr_line    = cur_line;
    inject     = 1'b0;
    ref_clr    = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (init_cnt_q >= INIT_LAST) state_d = S_IDLE;
        else                         init_cnt_d = init_cnt_q + 1;
      end
      S_IDLE: begin
        // The IDLE cycle spent noticing the pending refresh is the first stall cycle.
        if (ref_pend_q) begin
          ref_clr = 1'b1;
          if (REFRESH_CYCLES > 1) begin
            state_d = S_REFRESH;
            stall_d = STALL_LAST;
          end
        end else if (wr_acc) begin
          addr_d  = local_address;
          size_d  = size_eff;
          beat_d  = SZW'(1);
          wr_en   = 1'b1;
          wr_line = local_address;
          if (size_eff > SZW'(1)) state_d = S_WR_BURST;
        end else if (rd_acc) begin
          addr_d  = local_address;
          size_d  = size_eff;
          beat_d  = '0;
          state_d = S_RD_GEN;
        end
      end
      S_WR_BURST: begin
        if (local_write_req) begin
          wr_en  = 1'b1;
          beat_d = beat_q + SZW'(1);
          if (beat_q == size_q - SZW'(1)) state_d = S_IDLE;
        end
      end
      S_RD_GEN: begin
        inject = 1'b1;
        beat_d = beat_q + SZW'(1);
        if (beat_q == size_q - SZW'(1)) state_d = S_IDLE;
      end
      S_REFRESH: begin
        if (stall_q == 0) state_d = S_IDLE;
        else              stall_d = stall_q - 1;
      end
      default: state_d = S_INIT;
    endcase

    ref_pend_d = (ref_pend_q && !ref_clr) || ref_tick;
    if (state_q == S_INIT)         ref_cnt_d = '0;
    else if (ref_tick)             ref_cnt_d = '0;
    else if (REFRESH_PERIOD != 0)  ref_cnt_d = ref_cnt_q + 1;
    else                           ref_cnt_d = ref_cnt_q;

    proto_d = proto_q
            || (req && state_q == S_INIT)
            || (state_q == S_IDLE && wr_acc && local_read_req)
            || (req && local_burstbegin && state_q == S_WR_BURST);
  end

  always_ff @(posedge phy_clk) begin
    if (phy_rst) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      beat_q     <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      stall_q    <= '0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      beat_q     <= beat_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      stall_q    <= stall_d;
      proto_q    <= proto_d;
    end
  end

  // Contents survive reset; a reset edge suppresses any write in flight.
  always_ff @(posedge phy_clk) begin
    if (!phy_rst && wr_en) begin
      for (int unsigned k = 0; k < NBE; k++) begin
        if (local_be[k]) mem[wr_line[MEM_DEPTH_LOG2-1:0]][8*k +: 8] <= local_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge phy_clk) begin
    if (phy_rst) begin
      pv_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pv_q[0] <= inject;
      pd_q[0] <= mem_rd;
      for (int unsigned k = 1; k < PIPE; k++) begin
        pv_q[k] <= pv_q[k-1];
        pd_q[k] <= pd_q[k-1];
      end
      rvalid_q <= pv_q[PIPE-1];
      if (pv_q[PIPE-1]) rdata_q <= pd_q[PIPE-1];
    end
  end

endmodule

// File: tb/tb_sim_psd_ddr_burst_model.sv
// Directed bench for sim_psd_ddr_burst_model: table of write/read vectors plus
// hand sequences for init, refresh stall, proto_err and reset-abort cases.
module tb_sim_psd_ddr_burst_model;
  localparam int unsigned AW  = 26;
  localparam int unsigned DW  = 128;
  localparam int unsigned SZW = 3;
  localparam int unsigned BEW = 16;
  localparam int unsigned RDL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance (no refresh)
  logic          rst, rd, wr, bb;
  logic [AW-1:0] addr;
  logic [SZW-1:0] size;
  logic [DW-1:0] wdata, rdata;
  logic [BEW-1:0] be;
  logic          init_done, ready, rvalid, perr;

  // refresh instance
  logic          r_rst, r_rd, r_wr, r_bb;
  logic [AW-1:0] r_addr;
  logic [SZW-1:0] r_size;
  logic [DW-1:0] r_wdata, r_rdata;
  logic [BEW-1:0] r_be;
  logic          r_init_done, r_ready, r_rvalid, r_perr;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  sim_psd_ddr_burst_model #(
    .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .MEM_DEPTH_LOG2(16), .MAX_BURST(4),
    .RD_LATENCY(RDL), .INIT_CYCLES(16), .REFRESH_PERIOD(0), .REFRESH_CYCLES(8)
  ) dut (
    .phy_clk(clk), .phy_rst(rst), .local_init_done(init_done), .local_address(addr),
    .local_burstbegin(bb), .local_size(size), .local_ready(ready), .local_read_req(rd),
    .local_write_req(wr), .local_wdata(wdata), .local_be(be), .local_rdata(rdata),
    .local_rdata_valid(rvalid), .proto_err(perr)
  );

  sim_psd_ddr_burst_model #(
    .DDR_ADDR_WIDTH(AW), .DDR_DATA_WIDTH(DW), .MEM_DEPTH_LOG2(8), .MAX_BURST(4),
    .RD_LATENCY(RDL), .INIT_CYCLES(16), .REFRESH_PERIOD(20), .REFRESH_CYCLES(8)
  ) dut_r (
    .phy_clk(clk), .phy_rst(r_rst), .local_init_done(r_init_done), .local_address(r_addr),
    .local_burstbegin(r_bb), .local_size(r_size), .local_ready(r_ready), .local_read_req(r_rd),
    .local_write_req(r_wr), .local_wdata(r_wdata), .local_be(r_be), .local_rdata(r_rdata),
    .local_rdata_valid(r_rvalid), .proto_err(r_perr)
  );

  typedef struct {
    bit                 is_wr;
    logic [AW-1:0]      addr;
    logic [SZW-1:0]     size;
    int unsigned        nbeats;
    logic [DW-1:0]      d0;
    logic [BEW-1:0]     be;
    logic [3:0][DW-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t wr_v(logic [AW-1:0] a, logic [SZW-1:0] sz, int unsigned n,
                                logic [DW-1:0] d0, logic [BEW-1:0] b);
    vec_t v;
    v.is_wr = 1'b1; v.addr = a; v.size = sz; v.nbeats = n; v.d0 = d0; v.be = b; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t rd_v(logic [AW-1:0] a, logic [SZW-1:0] sz, int unsigned n,
                                logic [DW-1:0] e0, logic [DW-1:0] e1,
                                logic [DW-1:0] e2, logic [DW-1:0] e3);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.size = sz; v.nbeats = n; v.d0 = '0; v.be = '0;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic idle_inputs();
    rd = 1'b0; wr = 1'b0; bb = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [SZW-1:0] sz, input int unsigned n,
                          input logic [DW-1:0] d0, input logic [BEW-1:0] b);
    for (int unsigned i = 0; i < n; i++) begin
      wr = 1'b1; bb = (i == 0); addr = a; size = sz; be = b; wdata = d0 + DW'(i);
      tick();
    end
    idle_inputs();
  endtask

  task automatic do_read(input string nm, input logic [AW-1:0] a, input logic [SZW-1:0] sz,
                         input int unsigned nb, input logic [3:0][DW-1:0] ex);
    rd = 1'b1; bb = 1'b1; addr = a; size = sz;
    tick();
    idle_inputs();
    for (int unsigned k = 1; k <= RDL + nb; k++) begin
      tick();
      if (k >= RDL && k < RDL + nb) begin
        check({nm, "_valid"}, DW'(rvalid), DW'(1));
        check({nm, "_data"}, rdata, ex[k-RDL]);
      end else begin
        check({nm, "_novalid"}, DW'(rvalid), DW'(0));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][DW-1:0] ex;
    rst = 1'b1; r_rst = 1'b1; idle_inputs();
    addr = '0; size = '0; wdata = '0; be = '1;
    r_rd = 1'b0; r_wr = 1'b0; r_bb = 1'b0; r_addr = '0; r_size = '0; r_wdata = '0; r_be = '1;

    tbl.push_back(wr_v(26'h10, 3'd4, 4, 128'hA0, 16'hFFFF));
    tbl.push_back(rd_v(26'h10, 3'd4, 4, 128'hA0, 128'hA1, 128'hA2, 128'hA3));
    tbl.push_back(wr_v(26'h5, 3'd1, 1, {DW{1'b1}}, 16'hFFFF));
    tbl.push_back(wr_v(26'h5, 3'd1, 1, 128'h0, 16'h0001));
    tbl.push_back(rd_v(26'h5, 3'd1, 1, {{(DW-8){1'b1}}, 8'h00}, '0, '0, '0));
    tbl.push_back(wr_v(26'hFFFF, 3'd3, 3, 128'hB0, 16'hFFFF));
    tbl.push_back(rd_v(26'hFFFF, 3'd3, 3, 128'hB0, 128'hB1, 128'hB2, '0));
    tbl.push_back(rd_v(26'h0, 3'd2, 2, 128'hB1, 128'hB2, '0, '0));
    tbl.push_back(rd_v(26'h10000, 3'd1, 1, 128'hB1, '0, '0, '0));
    tbl.push_back(rd_v(26'h3FFFFFF, 3'd2, 2, 128'hB0, 128'hB1, '0, '0));
    tbl.push_back(wr_v(26'h104, 3'd1, 1, 128'hEE, 16'hFFFF));
    tbl.push_back(wr_v(26'h100, 3'd7, 5, 128'hC0, 16'hFFFF));
    tbl.push_back(rd_v(26'h100, 3'd7, 4, 128'hC0, 128'hC1, 128'hC2, 128'hC3));
    tbl.push_back(rd_v(26'h104, 3'd1, 1, 128'hEE, '0, '0, '0));
    tbl.push_back(wr_v(26'h201, 3'd1, 1, 128'h11, 16'hFFFF));
    tbl.push_back(wr_v(26'h200, 3'd0, 2, 128'hD0, 16'hFFFF));
    tbl.push_back(rd_v(26'h200, 3'd0, 1, 128'hD0, '0, '0, '0));
    tbl.push_back(rd_v(26'h201, 3'd1, 1, 128'h11, '0, '0, '0));

    // reset and init delay
    tick();
    check("rst_init_done", DW'(init_done), DW'(0));
    check("rst_ready", DW'(ready), DW'(0));
    check("rst_rvalid", DW'(rvalid), DW'(0));
    check("rst_rdata", rdata, '0);
    check("rst_perr", DW'(perr), DW'(0));
    tick(); tick();
    rst = 1'b0; r_rst = 1'b0;
    for (int unsigned k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("init_done_c%0d", k), DW'(init_done), DW'(k == 16));
      check($sformatf("init_ready_c%0d", k), DW'(ready), DW'(k == 16));
    end

    // table of vectors
    for (int unsigned i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].size, tbl[i].nbeats, tbl[i].d0, tbl[i].be);
      else do_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].size, tbl[i].nbeats, tbl[i].exp);
    end

    // write burst with gaps
    wr = 1'b1; bb = 1'b1; addr = 26'h300; size = 3'd3; be = '1; wdata = 128'h30;
    tick();
    wr = 1'b0; bb = 1'b0; wdata = 128'h99;
    tick();
    check("gap_ready", DW'(ready), DW'(1));
    wr = 1'b1; wdata = 128'h31; tick();
    wr = 1'b0; tick();
    wr = 1'b1; wdata = 128'h32; tick();
    idle_inputs();
    ex = '0; ex[0] = 128'h30; ex[1] = 128'h31; ex[2] = 128'h32;
    do_read("gap_rd", 26'h300, 3'd3, 3, ex);
    check("perr_clean", DW'(perr), DW'(0));

    // simultaneous read and write: write wins
    rd = 1'b1; wr = 1'b1; bb = 1'b1; addr = 26'h400; size = 3'd1; be = '1; wdata = 128'h77;
    tick();
    idle_inputs();
    check("both_perr", DW'(perr), DW'(1));
    for (int unsigned k = 1; k <= RDL + 1; k++) begin
      tick();
      check("both_norvalid", DW'(rvalid), DW'(0));
    end
    ex = '0; ex[0] = 128'h77;
    do_read("both_rd", 26'h400, 3'd1, 1, ex);

    // reset in the middle of RD_GEN
    rd = 1'b1; bb = 1'b1; addr = 26'h10; size = 3'd4;
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_rvalid", DW'(rvalid), DW'(0));
    check("rstmid_perr", DW'(perr), DW'(0));
    check("rstmid_init", DW'(init_done), DW'(0));
    rst = 1'b0;
    for (int unsigned k = 1; k <= 16; k++) begin
      if (k == 3) begin
        wr = 1'b1; bb = 1'b1; addr = 26'h10; size = 3'd1; wdata = 128'hDEAD;
      end else begin
        idle_inputs();
      end
      tick();
      check("rstmid_flush", DW'(rvalid), DW'(0));
      if (k == 3) check("init_req_perr", DW'(perr), DW'(1));
    end
    idle_inputs();
    check("reinit_done", DW'(init_done), DW'(1));
    rst = 1'b1; tick();
    rst = 1'b0;
    repeat (16) tick();
    ex = '0; ex[0] = 128'hA0; ex[1] = 128'hA1; ex[2] = 128'hA2; ex[3] = 128'hA3;
    do_read("intact_rd", 26'h10, 3'd4, 4, ex);

    // burstbegin inside WR_BURST flags error but beat still lands
    wr = 1'b1; bb = 1'b1; addr = 26'h500; size = 3'd2; be = '1; wdata = 128'h50;
    tick();
    check("wrbb_perr_pre", DW'(perr), DW'(0));
    wdata = 128'h52;
    tick();
    idle_inputs();
    check("wrbb_perr", DW'(perr), DW'(1));
    ex = '0; ex[0] = 128'h50; ex[1] = 128'h52;
    do_read("wrbb_rd", 26'h500, 3'd2, 2, ex);

    // refresh stall on dut_r, phase fixed by a fresh reset
    r_rst = 1'b1; tick();
    r_rst = 1'b0;
    repeat (16) tick();
    check("r_init", DW'(r_init_done), DW'(1));
    r_wr = 1'b1; r_addr = 26'h20; r_size = 3'd4; r_be = '1;
    for (int unsigned b = 0; b < 4; b++) begin
      r_bb = (b == 0); r_wdata = 128'h80 + DW'(b);
      tick();
    end
    r_wr = 1'b0; r_bb = 1'b0;
    repeat (9) tick();
    r_rd = 1'b1; r_bb = 1'b1; r_addr = 26'h20; r_size = 3'd4;
    tick();
    r_rd = 1'b0; r_bb = 1'b0;
    repeat (3) tick();
    check("r_lat_early", DW'(r_rvalid), DW'(0));
    tick();
    check("r_b0_valid", DW'(r_rvalid), DW'(1));
    check("r_b0_data", r_rdata, 128'h80);
    r_wr = 1'b1; r_bb = 1'b1; r_addr = 26'h40; r_size = 3'd2; r_wdata = 128'h60;
    tick();
    check("r_b1_data", r_rdata, 128'h81);
    check("r_wrburst_ready", DW'(r_ready), DW'(1));
    r_bb = 1'b0; r_wdata = 128'h61;
    tick();
    r_wr = 1'b0;
    check("r_b2_data", r_rdata, 128'h82);
    for (int unsigned n = 0; n <= 8; n++) begin
      if (n > 0) tick();
      check($sformatf("r_stall_ready_%0d", n), DW'(r_ready), DW'(n == 8));
      if (n == 1) begin
        check("r_b3_valid", DW'(r_rvalid), DW'(1));
        check("r_b3_data", r_rdata, 128'h83);
      end
      if (n == 2) check("r_drained", DW'(r_rvalid), DW'(0));
    end
    r_rd = 1'b1; r_bb = 1'b1; r_addr = 26'h40; r_size = 3'd2;
    tick();
    r_rd = 1'b0; r_bb = 1'b0;
    for (int unsigned k = 1; k <= RDL + 2; k++) begin
      tick();
      if (k == RDL)          check("r_wr_b0", r_rdata, 128'h60);
      else if (k == RDL + 1) check("r_wr_b1", r_rdata, 128'h61);
      check("r_wr_valid", DW'(r_rvalid), DW'(k >= RDL && k < RDL + 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
